// File: rtl/clocks_pkg.sv
// Shared definitions for the clock generation/measurement blocks:
// monitor state encoding, default counter width and nominal sound-chip periods.
package clocks_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int YM_PERIOD  = 16;
  localparam int SAA_PERIOD = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_t;

  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clk_monitor_if.sv
// Control-side bundle of the clock monitor: enable and clock under test in,
// measurement results and status out. slave = monitor, master = CPLD logic.
interface clk_monitor_if
  import clocks_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             present;
  logic             in_range;

  modport master (
    output en, clk_in,
    input  period, high_time, period_valid, present, in_range
  );

  modport slave (
    input  en, clk_in,
    output period, high_time, period_valid, present, in_range
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rise/fall detector for an asynchronous clock.
// GLITCH_FILTER_EN adds a level filter that rejects 1-cycle pulses (+1 cycle latency).
module sync_edge (
  input  logic fclk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic w_sync;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

`ifdef GLITCH_FILTER_EN
  logic r_filt;

  // Level only moves once two consecutive samples agree.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_filt <= 1'b0;
    end else if (r_s1 == r_s2) begin
      r_filt <= r_s2;
    end
  end

  assign w_sync = r_filt;
`else
  assign w_sync = r_s2;
`endif

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_sync;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;
endmodule

// File: rtl/clk_monitor.sv
// Measures period/high time of an asynchronous clock in fclk cycles and flags presence/range.
// Results register one cycle after a detected rise; see sync_edge for GLITCH_FILTER_EN.
module clk_monitor
  import clocks_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = 255,
  parameter int MIN_PERIOD = 6,
  parameter int MAX_PERIOD = 17
) (
  input  logic          fclk,
  input  logic          rst,
  clk_monitor_if.slave  mon
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_present;
  logic             r_in_range;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_in_win;

  sync_edge u_sync (
    .fclk    (fclk),
    .rst     (rst),
    .i_async (mon.clk_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_in_win = in_window(int'(r_per_cnt), MIN_PERIOD, MAX_PERIOD);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_hi_lat  <= '0;
    end else if (!mon.en) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_hi_lat  <= '0;
    end else begin
      if (w_rise) begin
        r_per_cnt <= ONE_V;
      end else if (r_per_cnt != CNT_MAX) begin
        r_per_cnt <= r_per_cnt + ONE_V;
      end

      if (w_rise) begin
        r_hi_cnt <= ONE_V;
      end else if (w_sync && (r_hi_cnt != CNT_MAX)) begin
        r_hi_cnt <= r_hi_cnt + ONE_V;
      end

      if (w_fall) begin
        r_hi_lat <= r_hi_cnt;
      end
    end
  end

  // A rise in the timeout cycle takes priority, so a late edge still measures.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_present   <= 1'b0;
      r_in_range  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!mon.en) begin
        r_state    <= ST_IDLE;
        r_present  <= 1'b0;
        r_in_range <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state <= ST_ARMED;
            end
          end
          ST_ARMED, ST_LOCKED: begin
            if (w_rise) begin
              r_state     <= ST_LOCKED;
              r_period    <= r_per_cnt;
              r_high_time <= r_hi_lat;
              r_valid     <= 1'b1;
              r_present   <= 1'b1;
              r_in_range  <= w_in_win;
            end else if (r_per_cnt >= TO_V) begin
              r_state    <= ST_IDLE;
              r_present  <= 1'b0;
              r_in_range <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mon.period       = r_period;
  assign mon.high_time    = r_high_time;
  assign mon.period_valid = r_valid;
  assign mon.present      = r_present;
  assign mon.in_range     = r_in_range;
endmodule
